// File: rtl/operand_fetch_pkg.sv
// Shared pipeline types for the register-file read path and the decode stage.
package project_types;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic REG_ENABLE = 1'b1;
  localparam logic RST_ENABLE = 1'b0;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } reg_info_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_t;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_BUBBLE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/i_fetch_rreg.sv
// Two-port register-file read interface; the slave returns WB-bypassed data combinationally.
interface i_fetch_rreg;
  import project_types::*;

  reg_info_t r1_info;
  reg_info_t r2_info;
  reg_data_t r1_data;
  reg_data_t r2_data;

  modport master (output r1_info, output r2_info, input r1_data, input r2_data);
  modport slave  (input r1_info, input r2_info, output r1_data, output r2_data);
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// Single read port resolver: zero register, EX forward, MEM forward, then register file.
module fwd_mux
  import project_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  reg_t              ex_wreg,
  input  logic              ex_is_load,
  input  reg_t              mem_wreg,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);

  logic ex_hit;
  logic mem_hit;

  // A load in EX has no data yet; the hazard logic covers that case with a bubble.
  assign ex_hit  = (ex_wreg.en == REG_ENABLE) && (ex_wreg.addr == addr) && !ex_is_load;
  assign mem_hit = (mem_wreg.en == REG_ENABLE) && (mem_wreg.addr == addr);

  always_comb begin
    data = rf_data;
    if (!en || (addr == '0)) begin
      data = '0;
    end else if (ex_hit) begin
      data = ex_wreg.data;
    end else if (mem_hit) begin
      data = mem_wreg.data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: regfile read requests, EX/MEM forwarding,
// load-use bubble insertion and the ID/EX operand register.
module operand_fetch
  import project_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              rs_en_i,
  input  logic              rt_en_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  reg_t              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  reg_t              mem_wreg_i,
  input  logic              stall_i,
  input  logic              flush_i,
  i_fetch_rreg.master       read,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output logic              opnd_valid_o,
  output logic              stall_req_o,
  output logic [CNT_W-1:0]  lu_stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              rs_rd_p0;
  logic              rt_rd_p0;
  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic              hazard_p0;
  logic              ld_dst_p0;

  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  lu_cnt_p1;

  fetch_state_t state_q;
  fetch_state_t state_d;

  // Stage p0: combinational read request, forwarding and hazard detection
  assign rs_rd_p0 = rs_en_i & id_valid_i;
  assign rt_rd_p0 = rt_en_i & id_valid_i;

  assign read.r1_info = '{en: rs_rd_p0, addr: rs_addr_i};
  assign read.r2_info = '{en: rt_rd_p0, addr: rt_addr_i};

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
    .en         (rs_rd_p0),
    .addr       (rs_addr_i),
    .ex_wreg    (ex_wreg_i),
    .ex_is_load (ex_is_load_i),
    .mem_wreg   (mem_wreg_i),
    .rf_data    (read.r1_data),
    .data       (op1_p0)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
    .en         (rt_rd_p0),
    .addr       (rt_addr_i),
    .ex_wreg    (ex_wreg_i),
    .ex_is_load (ex_is_load_i),
    .mem_wreg   (mem_wreg_i),
    .rf_data    (read.r2_data),
    .data       (op2_p0)
  );

  // A single flag per cycle, so rs == rt hitting the same load counts once.
  assign ld_dst_p0 = id_valid_i && ex_is_load_i && (ex_wreg_i.en == REG_ENABLE)
                     && (ex_wreg_i.addr != '0);
  assign hazard_p0 = ld_dst_p0 && ((rs_rd_p0 && (rs_addr_i == ex_wreg_i.addr)) ||
                                   (rt_rd_p0 && (rt_addr_i == ex_wreg_i.addr)));

  assign stall_req_o = hazard_p0 & ~flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = FS_RUN;
    end else if (!stall_i) begin
      state_d = hazard_p0 ? FS_BUBBLE : FS_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= FS_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: ID/EX register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      op1_p1    <= '0;
      op2_p1    <= '0;
      vld_p1    <= 1'b0;
      lu_cnt_p1 <= '0;
    end else if (flush_i) begin
      op1_p1 <= '0;
      op2_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (!stall_i) begin
      if (hazard_p0) begin
        op1_p1    <= '0;
        op2_p1    <= '0;
        vld_p1    <= 1'b0;
        lu_cnt_p1 <= sat_inc(lu_cnt_p1);
      end else begin
        op1_p1 <= op1_p0;
        op2_p1 <= op2_p0;
        vld_p1 <= id_valid_i;
      end
    end
  end

  assign op1_o          = op1_p1;
  assign op2_o          = op2_p1;
  assign opnd_valid_o   = vld_p1;
  assign lu_stall_cnt_o = lu_cnt_p1;

endmodule
